// File: rtl/input_conditioner_if.sv
// input_conditioner_if: raw board inputs in, debounced levels and press pulses out.
interface input_conditioner_if;
  logic [3:0] Button_raw;
  logic [3:0] Switch_raw;
  logic [3:0] Button_pulse;
  logic [3:0] Switch_out;
  logic [3:0] Button_level;
  modport master (
    output Button_raw, Switch_raw,
    input  Button_pulse, Switch_out, Button_level
  );
  modport slave (
    input  Button_raw, Switch_raw,
    output Button_pulse, Switch_out, Button_level
  );
endinterface

// File: rtl/input_conditioner.sv
// input_conditioner: synchronizes and debounces switches and buttons, emits one-hot single-cycle press pulses.
module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input logic                 CLK_In,
  input logic                 RST_In,
  input_conditioner_if.slave  io
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic [7:0]       s1_q, s1_d, s2_q, s2_d, lvl_q, lvl_d;
  logic [CNT_W-1:0] cnt_q [8];
  logic [CNT_W-1:0] cnt_d [8];
  logic [3:0]       btn_dly_q, btn_dly_d, pulse_q, pulse_d, rise;
  // bits [3:0] are buttons, [7:4] are switches
  always_comb begin
    s1_d      = {io.Switch_raw, io.Button_raw};
    s2_d      = s1_q;
    lvl_d     = lvl_q;
    for (int i = 0; i < 8; i++) begin
      cnt_d[i] = (s2_q[i] == lvl_q[i] || cnt_q[i] == LAST) ? '0 : cnt_q[i] + 1'b1;
      lvl_d[i] = (s2_q[i] != lvl_q[i] && cnt_q[i] == LAST) ? s2_q[i] : lvl_q[i];
    end
    btn_dly_d = lvl_q[3:0];
    rise      = lvl_q[3:0] & ~btn_dly_q;
    // abort (bit3) beats confirm (bit0); losers are dropped
    pulse_d   = rise[3] ? 4'b1000 :
                rise[0] ? 4'b0001 :
                rise[1] ? 4'b0010 :
                rise[2] ? 4'b0100 : 4'b0000;
  end
  always_ff @(posedge CLK_In or posedge RST_In) begin
    if (RST_In) begin
      s1_q      <= '0;
      s2_q      <= '0;
      lvl_q     <= '0;
      cnt_q     <= '{default: '0};
      btn_dly_q <= '0;
      pulse_q   <= '0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      lvl_q     <= lvl_d;
      cnt_q     <= cnt_d;
      btn_dly_q <= btn_dly_d;
      pulse_q   <= pulse_d;
    end
  end
  assign io.Button_pulse = pulse_q;
  assign io.Switch_out   = lvl_q[7:4];
  assign io.Button_level = lvl_q[3:0];
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: scenario tasks plus randomized bouncy inputs checked against a sample-window model.
module tb_input_conditioner;
  localparam int D = 4;
  localparam int ORD [4] = '{3, 0, 1, 2};
  logic CLK_In = 1'b0;
  logic RST_In = 1'b1;
  int   tests = 0;
  int   fails = 0;
  input_conditioner_if io ();
  input_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .CLK_In(CLK_In),
    .RST_In(RST_In),
    .io    (io)
  );
  always #5 CLK_In = ~CLK_In;
  // Model: a level flips once the raw input sampled at the D edges ending two edges ago all disagree with it.
  logic [7:0] hist [D+2];
  logic [7:0] m_lvl;
  logic [3:0] m_lvl_d, m_pulse;
  always @(posedge CLK_In or posedge RST_In) begin : mdl
    logic [3:0] rise;
    logic       flip;
    if (RST_In) begin
      for (int k = 0; k < D + 2; k++) hist[k] = '0;
      m_lvl = '0; m_lvl_d = '0; m_pulse = '0;
    end else begin
      rise = m_lvl[3:0] & ~m_lvl_d;
      m_pulse = '0;
      for (int k = 0; k < 4; k++) if (m_pulse == 0 && rise[ORD[k]]) m_pulse[ORD[k]] = 1'b1;
      m_lvl_d = m_lvl[3:0];
      for (int k = D + 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = {io.Switch_raw, io.Button_raw};
      for (int b = 0; b < 8; b++) begin
        flip = 1'b1;
        for (int k = 2; k <= D + 1; k++) if (hist[k][b] == m_lvl[b]) flip = 1'b0;
        if (flip) m_lvl[b] = ~m_lvl[b];
      end
    end
  end
  task automatic tick;
    @(posedge CLK_In);
    @(negedge CLK_In);
  endtask
  task automatic settle(input logic [3:0] b, input logic [3:0] s);
    io.Button_raw = b;
    io.Switch_raw = s;
    repeat (12) tick();
  endtask
  task automatic test_reset;
    io.Button_raw = 4'hF;
    io.Switch_raw = 4'hF;
    @(negedge CLK_In);
    RST_In = 1'b0;
    repeat (12) tick();
    @(posedge CLK_In);
    #2 RST_In = 1'b1;
    #1;
    tests++;
    if ({io.Button_pulse, io.Switch_out, io.Button_level} !== 12'h0) begin
      fails++;
      $display("FAIL reset_async got %h exp 000", {io.Button_pulse, io.Switch_out, io.Button_level});
    end
    io.Switch_raw = 4'h0;
    @(negedge CLK_In);
    RST_In = 1'b0;
    for (int e = 0; e < 12; e++) begin
      tick();
      tests++;
      if (io.Button_pulse !== (e == 6 ? 4'b1000 : 4'b0000)) begin
        fails++;
        $display("FAIL reset_held_pulse e=%0d got %b exp %b", e, io.Button_pulse, (e == 6 ? 4'b1000 : 4'b0000));
      end
      tests++;
      if ({io.Button_pulse, io.Button_level, io.Switch_out} !== {m_pulse, m_lvl[3:0], m_lvl[7:4]}) begin
        fails++;
        $display("FAIL reset_model e=%0d got %h exp %h", e, {io.Button_pulse, io.Button_level, io.Switch_out}, {m_pulse, m_lvl[3:0], m_lvl[7:4]});
      end
    end
    settle(4'h0, 4'h0);
  endtask
  task automatic test_clean_press;
    io.Button_raw = 4'b0001;
    for (int e = 0; e < 20; e++) begin
      tick();
      tests++;
      if (io.Button_level[0] !== (e >= 5) || io.Button_pulse !== (e == 6 ? 4'b0001 : 4'b0000)) begin
        fails++;
        $display("FAIL clean_press e=%0d got lvl=%b pulse=%b exp lvl=%b pulse=%b", e, io.Button_level[0], io.Button_pulse, e >= 5, (e == 6 ? 4'b0001 : 4'b0000));
      end
    end
    io.Button_raw = 4'b0000;
    for (int e = 0; e < 10; e++) begin
      tick();
      tests++;
      if (io.Button_pulse !== 4'b0000 || io.Button_level[0] !== (e < 5)) begin
        fails++;
        $display("FAIL release e=%0d got lvl=%b pulse=%b exp lvl=%b pulse=0000", e, io.Button_level[0], io.Button_pulse, e < 5);
      end
    end
  endtask
  task automatic test_bounce;
    for (int e = 0; e < 20; e++) begin
      io.Button_raw = {2'b00, (e < 4) ? ~e[0] : 1'b1, 1'b0};
      tick();
      tests++;
      if (io.Button_pulse !== (e == 10 ? 4'b0010 : 4'b0000)) begin
        fails++;
        $display("FAIL bounce e=%0d got %b exp %b", e, io.Button_pulse, (e == 10 ? 4'b0010 : 4'b0000));
      end
    end
    settle(4'h0, 4'h0);
    for (int e = 0; e < 14; e++) begin
      io.Button_raw = {2'b00, (e % 7) < 3, 1'b0};
      tick();
      tests++;
      if (io.Button_level !== 4'b0000 || io.Button_pulse !== 4'b0000) begin
        fails++;
        $display("FAIL glitch e=%0d got lvl=%b pulse=%b exp 0000", e, io.Button_level, io.Button_pulse);
      end
    end
    settle(4'h0, 4'h0);
  endtask
  task automatic test_simultaneous(input logic [3:0] b, input logic [3:0] exp_p);
    io.Button_raw = b;
    for (int e = 0; e < 12; e++) begin
      tick();
      tests++;
      if (io.Button_pulse !== (e == 6 ? exp_p : 4'b0000) || io.Button_level !== (e >= 5 ? b : 4'b0000)) begin
        fails++;
        $display("FAIL simultaneous b=%b e=%0d got pulse=%b lvl=%b exp pulse=%b", b, e, io.Button_pulse, io.Button_level, (e == 6 ? exp_p : 4'b0000));
      end
    end
    settle(4'h0, 4'h0);
  endtask
  task automatic test_switches;
    io.Switch_raw = 4'b0100;
    for (int e = 0; e < 10; e++) begin
      tick();
      tests++;
      if (io.Switch_out !== (e >= 5 ? 4'b0100 : 4'b0000)) begin
        fails++;
        $display("FAIL switch e=%0d got %b exp %b", e, io.Switch_out, (e >= 5 ? 4'b0100 : 4'b0000));
      end
    end
    for (int e = 0; e < 10; e++) begin
      io.Switch_raw = (e < 2) ? 4'b0110 : 4'b0100;
      tick();
      tests++;
      if (io.Switch_out !== 4'b0100) begin
        fails++;
        $display("FAIL switch_blip e=%0d got %b exp 0100", e, io.Switch_out);
      end
    end
    settle(4'h0, 4'h0);
  endtask
  task automatic test_reset_mid_count;
    io.Button_raw = 4'b0001;
    repeat (4) tick();
    RST_In = 1'b1;
    #1;
    tests++;
    if ({io.Button_pulse, io.Button_level} !== 8'h00) begin
      fails++;
      $display("FAIL midcount_reset got %h exp 00", {io.Button_pulse, io.Button_level});
    end
    tick();
    RST_In = 1'b0;
    for (int e = 0; e < 12; e++) begin
      tick();
      tests++;
      if (io.Button_pulse !== (e == 6 ? 4'b0001 : 4'b0000)) begin
        fails++;
        $display("FAIL midcount_pulse e=%0d got %b exp %b", e, io.Button_pulse, (e == 6 ? 4'b0001 : 4'b0000));
      end
    end
    settle(4'h0, 4'h0);
  endtask
  task automatic test_random;
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 5) == 0) io.Button_raw[b] = ~io.Button_raw[b];
        if ($urandom_range(0, 5) == 0) io.Switch_raw[b] = ~io.Switch_raw[b];
      end
      if ($urandom_range(0, 149) == 0) begin
        #2 RST_In = 1'b1;
        #1 RST_In = 1'b0;
      end
      tick();
      tests++;
      if ({io.Button_pulse, io.Button_level, io.Switch_out} !== {m_pulse, m_lvl[3:0], m_lvl[7:4]}) begin
        fails++;
        $display("FAIL random c=%0d got %h exp %h", c, {io.Button_pulse, io.Button_level, io.Switch_out}, {m_pulse, m_lvl[3:0], m_lvl[7:4]});
      end
      tests++;
      if ($countones(io.Button_pulse) > 1) begin
        fails++;
        $display("FAIL onehot c=%0d got %b exp at most one bit", c, io.Button_pulse);
      end
    end
  endtask
  initial begin
    io.Button_raw = 4'h0;
    io.Switch_raw = 4'h0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous(4'b1111, 4'b1000);
    test_simultaneous(4'b0111, 4'b0001);
    test_switches();
    test_reset_mid_count();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
